// File: rtl/rep_seq_pkg.sv
// Shared encodings for the REP-string sequencer: element sizes, FSM states
// and the per-size address step.
package rep_seq_pkg;

  typedef enum logic [1:0] {
    OPSZ_B = 2'd0,
    OPSZ_W = 2'd1,
    OPSZ_D = 2'd2,
    OPSZ_Q = 2'd3
  } opsize_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } state_e;

  function automatic logic [31:0] step_of(input logic [1:0] opsize);
    logic [31:0] step;
    case (opsize)
      OPSZ_B:  step = 32'd1;
      OPSZ_W:  step = 32'd2;
      OPSZ_D:  step = 32'd4;
      default: step = 32'd8;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/rep_seq_addr_step.sv
// Address stepper: optionally moves base by +/- element size and produces
// the last byte address of the element. All arithmetic wraps.
module rep_addr_step
  import rep_seq_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [1:0]        opsize,
  input  logic              df,
  input  logic              step_en,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_end
);

  logic [ADDR_W-1:0] step;

  always_comb begin
    step = ADDR_W'(step_of(opsize));
    if (!step_en)  addr = base;
    else if (df)   addr = base - step;
    else           addr = base + step;
    addr_end = addr + (step - ADDR_W'(1));
  end

endmodule

// File: rtl/rep_seq.sv
// REP-string sequencer: expands REP ops into one micro-op per iteration for
// the memory stage, passes other ops through with one cycle of latency.
module rep_seq
  import rep_seq_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              valid_in,
  input  logic              is_rep_in,
  input  logic [ADDR_W-1:0] rep_num,
  input  logic [1:0]        opsize_in,
  input  logic              df_in,
  input  logic [ADDR_W-1:0] mem_addr1_in,
  input  logic [ADDR_W-1:0] mem_addr2_in,
  input  logic              stall_in,
  output logic              ready_out,
  output logic              valid_out,
  output logic              is_rep_out,
  output logic              nop_out,
  output logic              last_out,
  output logic [1:0]        opsize_out,
  output logic [ADDR_W-1:0] mem_addr1,
  output logic [ADDR_W-1:0] mem_addr2,
  output logic [ADDR_W-1:0] mem_addr1_end,
  output logic [ADDR_W-1:0] mem_addr2_end,
  output logic [ADDR_W-1:0] rep_cnt_out
);

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic              is_rep_q, is_rep_d;
  logic              nop_q, nop_d;
  logic              last_q, last_d;
  logic              df_q, df_d;
  logic [1:0]        opsize_q, opsize_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic [ADDR_W-1:0] end1_q, end1_d, end2_q, end2_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              iter, accept;
  logic [1:0]        sz_sel;
  logic              df_sel;
  logic [ADDR_W-1:0] a1_base, a2_base, a1_nxt, a2_nxt, e1_nxt, e2_nxt;
  logic [ADDR_W-1:0] cnt_dec;

  assign iter      = (state_q == ST_ITER);
  assign ready_out = !iter && !stall_in && !(valid_q && !last_q);
  assign accept    = valid_in && ready_out;

  // While iterating the steppers walk the registered addresses; in IDLE
  // they pass the incoming op's addresses through unchanged.
  assign a1_base = iter ? addr1_q  : mem_addr1_in;
  assign a2_base = iter ? addr2_q  : mem_addr2_in;
  assign sz_sel  = iter ? opsize_q : opsize_in;
  assign df_sel  = iter ? df_q     : df_in;
  assign cnt_dec = cnt_q - ADDR_W'(1);

  rep_addr_step #(.ADDR_W(ADDR_W)) u_step1 (
    .base(a1_base), .opsize(sz_sel), .df(df_sel), .step_en(iter),
    .addr(a1_nxt), .addr_end(e1_nxt)
  );

  rep_addr_step #(.ADDR_W(ADDR_W)) u_step2 (
    .base(a2_base), .opsize(sz_sel), .df(df_sel), .step_en(iter),
    .addr(a2_nxt), .addr_end(e2_nxt)
  );

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    is_rep_d = is_rep_q;
    nop_d    = nop_q;
    last_d   = last_q;
    df_d     = df_q;
    opsize_d = opsize_q;
    addr1_d  = addr1_q;
    addr2_d  = addr2_q;
    end1_d   = end1_q;
    end2_d   = end2_q;
    cnt_d    = cnt_q;
    if (!stall_in) begin
      valid_d = 1'b0;
      if (iter) begin
        valid_d = 1'b1;
        addr1_d = a1_nxt;
        addr2_d = a2_nxt;
        end1_d  = e1_nxt;
        end2_d  = e2_nxt;
        cnt_d   = cnt_dec;
        last_d  = (cnt_dec == '0);
        if (cnt_dec == '0) state_d = ST_IDLE;
      end else if (accept) begin
        valid_d  = 1'b1;
        is_rep_d = is_rep_in;
        nop_d    = is_rep_in && (rep_num == '0);
        df_d     = df_in;
        opsize_d = opsize_in;
        addr1_d  = a1_nxt;
        addr2_d  = a2_nxt;
        end1_d   = e1_nxt;
        end2_d   = e2_nxt;
        if (!is_rep_in) begin
          cnt_d  = rep_num;
          last_d = 1'b1;
        end else if (rep_num == '0) begin
          cnt_d  = '0;
          last_d = 1'b1;
        end else begin
          cnt_d  = rep_num - ADDR_W'(1);
          last_d = (rep_num == ADDR_W'(1));
          if (rep_num != ADDR_W'(1)) state_d = ST_ITER;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      is_rep_q <= 1'b0;
      nop_q    <= 1'b0;
      last_q   <= 1'b0;
      df_q     <= 1'b0;
      opsize_q <= '0;
      addr1_q  <= '0;
      addr2_q  <= '0;
      end1_q   <= '0;
      end2_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      is_rep_q <= is_rep_d;
      nop_q    <= nop_d;
      last_q   <= last_d;
      df_q     <= df_d;
      opsize_q <= opsize_d;
      addr1_q  <= addr1_d;
      addr2_q  <= addr2_d;
      end1_q   <= end1_d;
      end2_q   <= end2_d;
      cnt_q    <= cnt_d;
    end
  end

  assign valid_out     = valid_q;
  assign is_rep_out    = is_rep_q;
  assign nop_out       = nop_q;
  assign last_out      = last_q;
  assign opsize_out    = opsize_q;
  assign mem_addr1     = addr1_q;
  assign mem_addr2     = addr2_q;
  assign mem_addr1_end = end1_q;
  assign mem_addr2_end = end2_q;
  assign rep_cnt_out   = cnt_q;

endmodule

// File: tb/tb_rep_seq.sv
// Scoreboard bench for rep_seq: directed ops push expected micro-ops, a
// negedge monitor pops one per micro-op consumed by the memory stage.
module tb_rep_seq;

  logic        clk = 1'b0;
  logic        clr, valid_in, is_rep_in, df_in, stall_in;
  logic [31:0] rep_num, mem_addr1_in, mem_addr2_in;
  logic [1:0]  opsize_in;
  logic        ready_out, valid_out, is_rep_out, nop_out, last_out;
  logic [1:0]  opsize_out;
  logic [31:0] mem_addr1, mem_addr2, mem_addr1_end, mem_addr2_end, rep_cnt_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a1, e1, a2, e2, cnt;
    logic        last, nop, isrep;
    logic [1:0]  sz;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, mon_g;

  always #5 clk = ~clk;

  rep_seq #(.ADDR_W(32)) dut (
    .clk(clk), .clr(clr), .valid_in(valid_in), .is_rep_in(is_rep_in),
    .rep_num(rep_num), .opsize_in(opsize_in), .df_in(df_in),
    .mem_addr1_in(mem_addr1_in), .mem_addr2_in(mem_addr2_in),
    .stall_in(stall_in), .ready_out(ready_out), .valid_out(valid_out),
    .is_rep_out(is_rep_out), .nop_out(nop_out), .last_out(last_out),
    .opsize_out(opsize_out), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
    .mem_addr1_end(mem_addr1_end), .mem_addr2_end(mem_addr2_end),
    .rep_cnt_out(rep_cnt_out)
  );

  function automatic exp_t mk(logic [31:0] a1, e1, a2, e2, cnt,
                              logic last, nop, isrep, logic [1:0] sz);
    exp_t e;
    e = '{a1:a1, e1:e1, a2:a2, e2:e2, cnt:cnt, last:last, nop:nop, isrep:isrep, sz:sz};
    return e;
  endfunction

  // A micro-op is consumed on the edge where valid_out is high and stall_in low.
  always @(negedge clk) begin
    if (valid_out && !stall_in) begin
      checks++;
      mon_g = '{a1:mem_addr1, e1:mem_addr1_end, a2:mem_addr2, e2:mem_addr2_end,
                cnt:rep_cnt_out, last:last_out, nop:nop_out, isrep:is_rep_out,
                sz:opsize_out};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL uop_unexpected got a1=%h cnt=%0d", mon_g.a1, mon_g.cnt);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_g !== mon_e) begin
          errors++;
          $display("FAIL uop got a1=%h e1=%h a2=%h e2=%h cnt=%0d last=%b nop=%b rep=%b sz=%0d want a1=%h e1=%h a2=%h e2=%h cnt=%0d last=%b nop=%b rep=%b sz=%0d",
                   mon_g.a1, mon_g.e1, mon_g.a2, mon_g.e2, mon_g.cnt, mon_g.last, mon_g.nop, mon_g.isrep, mon_g.sz,
                   mon_e.a1, mon_e.e1, mon_e.a2, mon_e.e2, mon_e.cnt, mon_e.last, mon_e.nop, mon_e.isrep, mon_e.sz);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rep, input logic [31:0] num, input logic [1:0] sz,
                       input logic df, input logic [31:0] a1, input logic [31:0] a2);
    int n;
    valid_in = 1'b1; is_rep_in = rep; rep_num = num; opsize_in = sz;
    df_in = df; mem_addr1_in = a1; mem_addr2_in = a2;
    n = 0;
    while (!ready_out && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout got ready=%b want 1", ready_out);
    end
    tick();
    valid_in = 1'b0;
  endtask

  initial begin
    clr = 1'b1; valid_in = 1'b0; is_rep_in = 1'b0; df_in = 1'b0; stall_in = 1'b0;
    rep_num = '0; opsize_in = '0; mem_addr1_in = '0; mem_addr2_in = '0;
    tick(); tick();
    chk("reset_outputs", 64'({valid_out, is_rep_out, nop_out, last_out, opsize_out,
         mem_addr1, mem_addr2, mem_addr1_end, mem_addr2_end, rep_cnt_out} != '0), 64'd0);
    chk("reset_ready", 64'(ready_out), 64'd1);
    clr = 1'b0;
    tick();

    // Non-REP pass-through
    exp_q.push_back(mk(32'h1000, 32'h1003, 32'h5000, 32'h5003, 32'd7, 1, 0, 0, 2'd2));
    issue(0, 32'd7, 2'd2, 0, 32'h1000, 32'h5000);
    chk("norep_valid", 64'(valid_out), 64'd1);
    chk("norep_end1", 64'(mem_addr1_end), 64'h1003);
    chk("norep_ready", 64'(ready_out), 64'd1);

    // REP 3, word size, incrementing
    exp_q.push_back(mk(32'h2000, 32'h2001, 32'h3000, 32'h3001, 32'd2, 0, 0, 1, 2'd1));
    exp_q.push_back(mk(32'h2002, 32'h2003, 32'h3002, 32'h3003, 32'd1, 0, 0, 1, 2'd1));
    exp_q.push_back(mk(32'h2004, 32'h2005, 32'h3004, 32'h3005, 32'd0, 1, 0, 1, 2'd1));
    issue(1, 32'd3, 2'd1, 0, 32'h2000, 32'h3000);
    chk("rep3_ready_c1", 64'(ready_out), 64'd0);
    tick();
    chk("rep3_ready_c2", 64'(ready_out), 64'd0);
    tick();
    chk("rep3_ready_c3", 64'(ready_out), 64'd1);

    // REP 2, byte size, decrementing through zero
    exp_q.push_back(mk(32'h0, 32'h0, 32'h10, 32'h10, 32'd1, 0, 0, 1, 2'd0));
    exp_q.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF, 32'hF, 32'd0, 1, 0, 1, 2'd0));
    issue(1, 32'd2, 2'd0, 1, 32'h0, 32'h10);
    tick();

    // REP with zero count
    exp_q.push_back(mk(32'h100, 32'h107, 32'h200, 32'h207, 32'd0, 1, 1, 1, 2'd3));
    issue(1, 32'd0, 2'd3, 0, 32'h100, 32'h200);
    chk("rep0_nop", 64'(nop_out), 64'd1);
    chk("rep0_ready", 64'(ready_out), 64'd1);

    // Back-to-back: REP 1 then a non-REP whose end address wraps
    exp_q.push_back(mk(32'h50, 32'h50, 32'h60, 32'h60, 32'd0, 1, 0, 1, 2'd0));
    exp_q.push_back(mk(32'hFFFF_FFFC, 32'h3, 32'h8, 32'hF, 32'd0, 1, 0, 0, 2'd3));
    issue(1, 32'd1, 2'd0, 0, 32'h50, 32'h60);
    chk("rep1_ready", 64'(ready_out), 64'd1);
    issue(0, 32'd0, 2'd3, 0, 32'hFFFF_FFFC, 32'h8);

    // REP 4 with a two-cycle stall on iteration 2
    exp_q.push_back(mk(32'h4000, 32'h4003, 32'h8000, 32'h8003, 32'd3, 0, 0, 1, 2'd2));
    exp_q.push_back(mk(32'h4004, 32'h4007, 32'h8004, 32'h8007, 32'd2, 0, 0, 1, 2'd2));
    exp_q.push_back(mk(32'h4008, 32'h400B, 32'h8008, 32'h800B, 32'd1, 0, 0, 1, 2'd2));
    exp_q.push_back(mk(32'h400C, 32'h400F, 32'h800C, 32'h800F, 32'd0, 1, 0, 1, 2'd2));
    issue(1, 32'd4, 2'd2, 0, 32'h4000, 32'h8000);
    tick();
    stall_in = 1'b1;
    chk("stall_ready", 64'(ready_out), 64'd0);
    tick();
    chk("stall_hold1", {mem_addr1, rep_cnt_out}, {32'h4004, 32'd2});
    tick();
    chk("stall_hold2", {mem_addr1, rep_cnt_out}, {32'h4004, 32'd2});
    stall_in = 1'b0;
    tick();
    chk("stall_resume", {mem_addr1, rep_cnt_out}, {32'h4008, 32'd1});
    tick();

    // clr during iteration 2 of 5
    exp_q.push_back(mk(32'h10, 32'h10, 32'h20, 32'h20, 32'd4, 0, 0, 1, 2'd0));
    exp_q.push_back(mk(32'h11, 32'h11, 32'h21, 32'h21, 32'd3, 0, 0, 1, 2'd0));
    issue(1, 32'd5, 2'd0, 0, 32'h10, 32'h20);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_valid", 64'(valid_out), 64'd0);
    chk("clr_ready", 64'(ready_out), 64'd1);
    chk("clr_outputs", 64'({is_rep_out, nop_out, last_out, opsize_out,
         mem_addr1, mem_addr2, mem_addr1_end, mem_addr2_end, rep_cnt_out} != '0), 64'd0);
    repeat (4) tick();
    chk("clr_idle_valid", 64'(valid_out), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
